// File: rtl/store_merge_unit_pkg.sv
// rtl/store_merge_unit_pkg.sv - shared encodings, state type and alignment helper for the store merge unit
//
// Purpose: common definitions imported by store_merge_unit and store_lane_merge.
// Contents:
//   SIZE_BYTE/HALF/WORD/RSVD  request size encodings
//   smu_state_t               sequencer states
//   is_misaligned()           size/low-address legality check

package store_merge_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_WRITE   = 2'd3
  } smu_state_t;

  // Reserved size is always rejected; bytes can sit on any lane.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// rtl/store_merge_unit_lane_merge.sv - combinational byte/half lane insertion into a read word
//
// Purpose: little-endian merge of store data into the word read back from memory.
// Ports:
//   old_word  in  32  word read from memory
//   data      in  16  low half of the store operand (upper operand bits never matter)
//   size      in  2   SIZE_BYTE or SIZE_HALF (anything else treated as byte)
//   lane      in  2   byte address within the word
//   merged    out 32  word to write back

module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    if (size == SIZE_HALF) begin
      if (lane[1]) merged[31:16] = data;
      else         merged[15:0]  = data;
    end else begin
      merged[{lane, 3'b000} +: 8] = data[7:0];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - sub-word store narrowing via read-modify-write on a byte-enable-less memory
//
// Purpose: accepts a store request, writes words directly and performs read/merge/write for
// bytes and halfwords. Misaligned or reserved-size requests are rejected without memory traffic;
// a read that never returns within RD_TIMEOUT wait cycles is abandoned with an error pulse.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (req_ready registered)
//   req_addr/req_data/req_size  byte address, operand, size (00 byte, 01 half, 10 word)
//   mem_addr                  word-aligned address, held for the whole operation
//   mem_rd_en                 one-cycle read strobe
//   mem_rd_data/mem_rd_valid  read return (only honoured while waiting for it)
//   mem_wr_en/mem_wr_data     one-cycle write strobe and merged word
//   done/misaligned/error     one-cycle completion / rejection / read-timeout pulses

module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wr_data,
  output logic                  done,
  output logic                  misaligned,
  output logic                  error
);

  // Counter value seen in the last permitted wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(RD_TIMEOUT - 1);

  smu_state_t  state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic [15:0] data_q;
  logic [31:0] merged;
  logic        accept;

  assign accept = req_valid && req_ready;

  store_lane_merge u_lane_merge (
    .old_word (mem_rd_data),
    .data     (data_q),
    .size     (size_q),
    .lane     (lane_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      req_ready   <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      misaligned  <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            if (is_misaligned(req_size, req_addr[1:0])) begin
              // Rejected requests leave the unit ready for the next one.
              misaligned <= 1'b1;
            end else begin
              req_ready <= 1'b0;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              lane_q    <= req_addr[1:0];
              size_q    <= req_size;
              data_q    <= req_data[15:0];
              if (req_size == SIZE_WORD) begin
                mem_wr_data <= req_data;
                mem_wr_en   <= 1'b1;
                done        <= 1'b1;
                state       <= ST_WRITE;
              end else begin
                mem_rd_en <= 1'b1;
                state     <= ST_RD_REQ;
              end
            end
          end
        end
        ST_RD_REQ: begin
          wait_cnt <= '0;
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // A return in the final wait cycle still completes the store.
          if (mem_rd_valid) begin
            mem_wr_data <= merged;
            mem_wr_en   <= 1'b1;
            done        <= 1'b1;
            state       <= ST_WRITE;
          end else if (wait_cnt == WAIT_LAST) begin
            error     <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_WRITE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
